sram_ctrl: RTL and testbench

Multi-cycle controller placed between the MEM stage and an external 16-bit asynchronous SRAM. It serialises each 32-bit pipeline load or store into two 16-bit SRAM phases with programmable wait states. While an access is in flight it holds `ready` low so the pipeline freezes. It also owns the data-address mapping: byte address minus 1024, then word index.

---
 rtl/arm_mem_pkg.sv | 19 +
 rtl/sram_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared constants and types for the data-memory path
package arm_mem_pkg;

  // Byte address that maps onto SRAM word 0.
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

  // External SRAM geometry: half-word address width and data width.
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  // Access sequencer: idle, low half-word phase, high half-word phase, handshake.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } sram_state_t;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit load/store to 16-bit async SRAM bridge with wait states
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_OE_N
);

  localparam int             CW       = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES - 1);

  sram_state_t         state;
  logic [CW-1:0]       wait_cnt;
  logic                op_wr;
  logic [SRAM_AW-2:0]  word;
  logic [31:0]         wdata;

  logic                req;
  logic                in_phase;
  logic                cnt_last;
  logic [31:0]         offset;
  logic                dq_oe;
  logic [SRAM_DW-1:0]  dq_out;
  logic                unused_offset_bits;

  assign req      = wr_en | rd_en;
  assign in_phase = (state == ST_LOW) || (state == ST_HIGH);
  assign cnt_last = (wait_cnt == CNT_LAST);

  // Word index wraps modulo 2^17, so addresses below the base simply alias high.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  // Sequencer: each half-word phase lasts WAIT_CYCLES cycles, then a one-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (req) state <= ST_LOW;
        end
        ST_LOW: begin
          if (cnt_last) begin
            state    <= ST_HIGH;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_last) begin
            state    <= ST_DONE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Request capture: inputs are only looked at in IDLE so the pipeline may change them freely afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr <= 1'b0;
      word  <= '0;
      wdata <= '0;
    end else if (state == ST_IDLE && req) begin
      op_wr <= wr_en;
      word  <= offset[18:2];
      wdata <= write_data;
    end
  end

  // Load data capture on the last cycle of each phase, when the SRAM output has settled longest.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if (!op_wr && cnt_last) begin
      if (state == ST_LOW)  read_data[15:0]  <= SRAM_DQ;
      if (state == ST_HIGH) read_data[31:16] <= SRAM_DQ;
    end
  end

  // SRAM address, write strobe and pipeline handshake decode.
  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    ready     = 1'b0;
    case (state)
      ST_IDLE: ready = ~req;
      ST_LOW:  SRAM_ADDR = {word, 1'b0};
      ST_HIGH: SRAM_ADDR = {word, 1'b1};
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
    // Strobe rises one cycle before the phase ends so address and data are held across the WE edge.
    if (op_wr && in_phase && !cnt_last) SRAM_WE_N = 1'b0;
  end

  // The bus is only driven while a store is in one of its two data phases.
  assign dq_oe   = op_wr && in_phase;
  assign dq_out  = (state == ST_HIGH) ? wdata[31:16] : wdata[15:0];
  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with SRAM and access model
module tb_sram_ctrl;

  localparam int W    = 3;
  localparam int LAST = 2 * W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b0;

  sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // Undriven bus reads as all ones.
  pullup (SRAM_DQ);

  // External SRAM: written on the rising WE edge, drives its output at the end of each read phase.
  logic [15:0] sram    [0:262143];
  logic [15:0] exp_mem [0:262143];
  logic [15:0] sram_q;
  logic        tb_drive;

  always @(posedge SRAM_WE_N) if (!rst) sram[SRAM_ADDR] <= SRAM_DQ;

  // Access model: cycle index k, 0 = idle, 1..2W = phases, 2W+1 = handshake.
  int          m_k;
  bit          m_wr;
  logic [16:0] m_word;
  logic [31:0] m_wdata, m_rd;

  assign sram_q   = sram[SRAM_ADDR];
  assign tb_drive = !m_wr && (m_k == W || m_k == 2 * W);
  assign SRAM_DQ  = tb_drive ? sram_q : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      m_k  <= 0;
      m_wr <= 1'b0;
      m_rd <= 32'h0;
    end else if (m_k == 0) begin
      if (wr_en | rd_en) begin
        m_k     <= 1;
        m_wr    <= wr_en;
        m_word  <= 17'((address - 32'd1024) >> 2);
        m_wdata <= write_data;
      end
    end else begin
      if (!m_wr && m_k == W)     m_rd[15:0]  <= exp_mem[{m_word, 1'b0}];
      if (!m_wr && m_k == 2 * W) m_rd[31:16] <= exp_mem[{m_word, 1'b1}];
      if (m_wr && m_k == 2 * W) begin
        exp_mem[{m_word, 1'b0}] <= m_wdata[15:0];
        exp_mem[{m_word, 1'b1}] <= m_wdata[31:16];
      end
      m_k <= (m_k == LAST) ? 0 : m_k + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    bit          in_acc, hi;
    int          ph;
    logic [17:0] e_addr;
    logic        e_we, e_rdy;
    if (chk_on) begin
      in_acc = (m_k >= 1) && (m_k <= 2 * W);
      hi     = (m_k > W);
      ph     = hi ? m_k - W - 1 : m_k - 1;
      e_addr = in_acc ? {m_word, hi} : 18'h0;
      e_we   = !(in_acc && m_wr && ph < W - 1);
      e_rdy  = (m_k == 0) ? !(wr_en | rd_en) : (m_k == LAST);
      chk("ready", 32'(ready), 32'(e_rdy));
      chk("sram_addr", 32'(SRAM_ADDR), 32'(e_addr));
      chk("we_n", 32'(SRAM_WE_N), 32'(e_we));
      chk("read_data", read_data, m_rd);
      chk("ctl_pins", {28'h0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'h0);
      if (in_acc && m_wr)
        chk("dq_write", 32'(SRAM_DQ), 32'(hi ? m_wdata[31:16] : m_wdata[15:0]));
      else if (!tb_drive)
        chk("dq_released", 32'(SRAM_DQ), 32'h0000_FFFF);
    end
  end

  int          lat;
  logic [17:0] low_addr;

  // One access: request for a cycle, then optionally keep enables high and scramble inputs mid-access.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input bit hold,
                        output int l, output logic [17:0] la);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    @(posedge clk); #1;
    if (hold) begin
      address    = addr ^ 32'h0000_F0F0;
      write_data = ~data;
    end else begin
      wr_en = 1'b0; rd_en = 1'b0;
    end
    l = 0; la = '0;
    do begin
      @(negedge clk);
      l++;
      if (l == 1) la = SRAM_ADDR;
    end while (!ready && l < 20);
    #1 wr_en = 1'b0; rd_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'h1);
    chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_dq", 32'(SRAM_DQ), 32'h0000_FFFF);
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, lat, low_addr);
    chk("st1024_latency", 32'(lat), 32'd7);
    chk("st1024_w0", 32'(sram[0]), 32'h0000_BEEF);
    chk("st1024_w1", 32'(sram[1]), 32'h0000_DEAD);

    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, lat, low_addr);
    chk("ld1024_latency", 32'(lat), 32'd7);
    chk("ld1024_data", read_data, 32'hDEADBEEF);

    access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, lat, low_addr);
    chk("st1028_latency", 32'(lat), 32'd7);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lat, low_addr);
    chk("ld1028_latency", 32'(lat), 32'd7);
    chk("ld1028_low_addr", 32'(low_addr), 32'h2);
    chk("ld1028_data", read_data, 32'h12345678);
    chk("st1028_w2", 32'(sram[2]), 32'h0000_5678);
    chk("st1028_w3", 32'(sram[3]), 32'h0000_1234);

    access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0, lat, low_addr);
    chk("both_w4", 32'(sram[4]), 32'h0000_F00D);
    chk("both_w5", 32'(sram[5]), 32'h0000_CAFE);
    chk("both_read_held", read_data, 32'h12345678);

    access(1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 1'b1, lat, low_addr);
    chk("wrap_latency", 32'(lat), 32'd7);
    chk("wrap_low_addr", 32'(low_addr), 32'h3FFFE);
    chk("wrap_lo", 32'(sram[18'h3FFFE]), 32'h0000_5A5A);
    chk("wrap_hi", 32'(sram[18'h3FFFF]), 32'h0000_A5A5);

    wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_we_n", 32'(SRAM_WE_N), 32'h1);
    chk("abort_dq", 32'(SRAM_DQ), 32'h0000_FFFF);
    chk("abort_read_data", read_data, 32'h0);
    chk("abort_addr", 32'(SRAM_ADDR), 32'h0);
    @(posedge clk); #1;

    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, lat, low_addr);
    chk("post_abort_latency", 32'(lat), 32'd7);
    chk("post_abort_data", read_data, 32'h12345678);

    repeat (2) @(posedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
